// File: rtl/run_event_pkg.sv
// run_event_pkg
// Shared constants and the event record type for the run-of-ones event logger.
//   TS_WIDTH_DEF  : default timestamp width
//   SEQ_WIDTH_DEF : default sequence number width
//   DEPTH_DEF     : default FIFO depth
//   run_event_t   : {ts, seq} record at the default widths
package run_event_pkg;

    localparam int unsigned TS_WIDTH_DEF  = 16;
    localparam int unsigned SEQ_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF     = 4;

    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0]  ts;
        logic [SEQ_WIDTH_DEF-1:0] seq;
    } run_event_t;

endpackage

// File: rtl/event_fifo.sv
// event_fifo
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : synchronous flush, wins over push and pop
//   i_push       : write request; accepted if not full or popping this cycle
//   i_wdata      : write data
//   i_pop        : read request; ignored while empty
//   o_valid      : FIFO non-empty
//   o_full       : FIFO holds DEPTH entries
//   o_rdata      : head entry (0 while empty)
//   o_count      : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module event_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_pop_en;
    logic w_push_en;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == CntFull);
    assign w_pop_en  = i_pop & o_valid & ~i_flush;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_push_en = i_push & (~o_full | w_pop_en) & ~i_flush;
    assign o_rdata   = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/run_event_logger.sv
// run_event_logger
// Turns rising edges of the run detector output into {timestamp, sequence} records,
// buffers them in a FWFT FIFO and hands them out over valid/ready.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   detect_in      : detector output; each rising edge is one event
//   clear          : synchronous clear of FIFO, ts, seq and overflow
//   evt_valid      : head record available
//   evt_ready      : consumer takes the head when evt_valid is high
//   evt_timestamp  : head record timestamp
//   evt_seq        : head record sequence number
//   evt_level      : FIFO occupancy
//   overflow       : sticky, set when an event was dropped on a full FIFO
module run_event_logger
    import run_event_pkg::*;
#(
    parameter int unsigned TS_WIDTH  = TS_WIDTH_DEF,
    parameter int unsigned SEQ_WIDTH = SEQ_WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 detect_in,
    input  logic                 clear,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [TS_WIDTH-1:0]  evt_timestamp,
    output logic [SEQ_WIDTH-1:0] evt_seq,
    output logic [LW-1:0]        evt_level,
    output logic                 overflow
);

    localparam int unsigned RW = TS_WIDTH + SEQ_WIDTH;

    logic [TS_WIDTH-1:0]  r_ts;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic                 r_detect_q;
    logic                 r_overflow;

    logic          w_event;
    logic          w_pop;
    logic          w_full;
    logic          w_drop;
    logic [RW-1:0] w_rdata;

    assign w_event = detect_in & ~r_detect_q & ~clear;
    assign w_pop   = evt_valid & evt_ready & ~clear;
    assign w_drop  = w_event & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_seq      <= '0;
            r_detect_q <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // The edge detector keeps sampling through clear so a held input
            // does not produce a spurious event afterwards.
            r_detect_q <= detect_in;
            if (clear) begin
                r_ts       <= '0;
                r_seq      <= '0;
                r_overflow <= 1'b0;
            end else begin
                r_ts <= r_ts + TS_WIDTH'(1);
                // seq advances on dropped events too, leaving visible gaps.
                if (w_event) begin
                    r_seq <= r_seq + SEQ_WIDTH'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    event_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (clear),
        .i_push  (w_event),
        .i_wdata ({r_ts, r_seq}),
        .i_pop   (w_pop),
        .o_valid (evt_valid),
        .o_full  (w_full),
        .o_rdata (w_rdata),
        .o_count (evt_level)
    );

    assign evt_timestamp = w_rdata[RW-1:SEQ_WIDTH];
    assign evt_seq       = w_rdata[SEQ_WIDTH-1:0];
    assign overflow      = r_overflow;

endmodule
